// File: rtl/alu_seq_n.sv
// alu_seq_n: ALU with single-cycle logic/arith/shift ops and a WIDTH-step shift-add multiplier.
// Define ALU_SEQ_DIV_EN to turn Op 111 into an unsigned restoring divide instead of SRA.
module alu_seq_n #(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result,
  output logic [WIDTH-1:0]   o_mulhi,
  output logic               o_zero,
  output logic               o_overflow,
  output logic               o_carryout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_b;
  logic                 r_done, r_zero, r_ovf, r_cy;
  logic [WIDTH-1:0]     r_res, r_hi;
  logic [WIDTH-1:0]     w_b2, w_res;
  logic [WIDTH:0]       w_sum, w_mul_sum;
  logic                 w_sub, w_arith, w_big, w_multi, w_ovf;
  logic [2*WIDTH-1:0]   w_nx;
  assign w_sub   = i_op == 3'b011;
  assign w_arith = i_op[2:1] == 2'b01;
  assign w_b2    = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b2} + (WIDTH+1)'(w_sub);
  assign w_ovf   = (i_a[WIDTH-1] == w_b2[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_big   = 32'(i_shamt) >= WIDTH;
  // Product register: high half accumulates, low half holds the multiplier being shifted out.
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
`ifdef ALU_SEQ_DIV_EN
  logic               r_div;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH-1:0]   w_rsub;
  logic               w_ge;
  assign w_multi = i_op == 3'b101 || i_op == 3'b111;
  assign w_rem   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge    = w_rem >= {1'b0, r_b};
  assign w_rsub  = w_rem[WIDTH-1:0] - r_b;
  // Division by zero falls out naturally: quotient all ones, remainder A.
  assign w_nx    = r_div ? {w_ge ? w_rsub : w_rem[WIDTH-1:0], r_p[WIDTH-2:0], w_ge}
                         : {w_mul_sum, r_p[WIDTH-1:1]};
`else
  assign w_multi = i_op == 3'b101;
  assign w_nx    = {w_mul_sum, r_p[WIDTH-1:1]};
`endif
  always_comb begin
    w_res = '0;
    case (i_op)
      3'b000:         w_res = i_a & i_b;
      3'b001:         w_res = i_a | i_b;
      3'b010, 3'b011: w_res = w_sum[WIDTH-1:0];
      3'b100:         w_res = WIDTH'($signed(i_a) < $signed(i_b));
      3'b110:         w_res = w_big ? '0 : i_a << i_shamt;
`ifndef ALU_SEQ_DIV_EN
      3'b111:         w_res = w_big ? {WIDTH{i_a[WIDTH-1]}} : WIDTH'($signed(i_a) >>> i_shamt);
`endif
      default:        w_res = '0;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cy    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      r_div   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == ITER) begin
        r_p   <= w_nx;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH-1)) begin
          r_res   <= w_nx[WIDTH-1:0];
          r_hi    <= w_nx[2*WIDTH-1:WIDTH];
          r_zero  <= w_nx[WIDTH-1:0] == '0;
          r_ovf   <= 1'b0;
          r_cy    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= FIN;
        end
      end else if (i_start && w_multi) begin
        r_p     <= {{WIDTH{1'b0}}, i_a};
        r_b     <= i_b;
        r_cnt   <= '0;
        r_state <= ITER;
`ifdef ALU_SEQ_DIV_EN
        r_div   <= i_op == 3'b111;
`endif
      end else if (i_start) begin
        r_res   <= w_res;
        r_hi    <= '0;
        r_zero  <= w_res == '0;
        r_ovf   <= w_arith & w_ovf;
        r_cy    <= w_arith & w_sum[WIDTH];
        r_done  <= 1'b1;
        r_state <= FIN;
      end else begin
        r_state <= IDLE;
      end
    end
  end
  assign o_busy     = r_state == ITER;
  assign o_done     = r_done;
  assign o_result   = r_res;
  assign o_mulhi    = r_hi;
  assign o_zero     = r_zero;
  assign o_overflow = r_ovf;
  assign o_carryout = r_cy;
endmodule
